// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode, state encodings and decode helpers shared by the control sequencer.
package ctrl_pkg;
  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_ADDI  = 3'd1,
    OP_XOR   = 3'd2,
    OP_LOAD  = 3'd3,
    OP_STORE = 3'd4,
    OP_JUMP  = 3'd5,
    OP_SUB   = 3'd6,
    OP_SHF   = 3'd7
  } opcode_e;
  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t FETCH  = 3'd1;
  localparam state_t DECODE = 3'd2;
  localparam state_t EXEC   = 3'd3;
  localparam state_t MEM    = 3'd4;
  localparam state_t WB     = 3'd5;
  localparam state_t DONE   = 3'd6;
  function automatic logic usesImm(input logic [2:0] op);
    return op == OP_ADDI || op == OP_LOAD || op == OP_STORE;
  endfunction
endpackage

// File: rtl/ctrl_fsm_if.sv
// ctrl_fsm_if: fetch, memory and datapath-enable signals of the control sequencer.
interface ctrl_fsm_if #(parameter int OPW = 3, parameter int CNT_W = 16);
  logic start, instrValid, halt, memReady, zero;
  logic [OPW-1:0] opcode;
  logic instrReady, regWrite, memRead, memWrite, aluSrc, branch, jump, pcEn, done, memErr;
  logic [CNT_W-1:0] instrCount;
  modport master(
    input start, instrValid, opcode, halt, memReady, zero,
    output instrReady, regWrite, memRead, memWrite, aluSrc, branch, jump, pcEn, done, memErr, instrCount
  );
  modport slave(
    output start, instrValid, opcode, halt, memReady, zero,
    input instrReady, regWrite, memRead, memWrite, aluSrc, branch, jump, pcEn, done, memErr, instrCount
  );
endinterface

// File: rtl/ctrl_mem_wait.sv
// ctrl_mem_wait: counts MEM cycles and flags a timeout when memReady never arrives.
module ctrl_mem_wait #(parameter int MEM_TIMEOUT = 8) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic memReady,
  output logic timeout
);
  localparam int W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  logic [W-1:0] waitCnt;
  always_ff @(posedge clk)
    if (reset || clr) waitCnt <= '0;
    else if (en) waitCnt <= waitCnt + 1'b1;
  assign timeout = en && !memReady && waitCnt == W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving PC, register file and data memory.
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OPW = 3,
  parameter int MEM_TIMEOUT = 8,
  parameter int JUMP_COND = 0,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  ctrl_fsm_if.master bus
);
  state_t state, nextState;
  logic [OPW-1:0] irOp;
  logic [CNT_W-1:0] instrCount;
  logic memErr, timeout;
  logic isLoad, isStore, isJump;
  assign isLoad = irOp == OPW'(OP_LOAD);
  assign isStore = irOp == OPW'(OP_STORE);
  assign isJump = irOp == OPW'(OP_JUMP);
  ctrl_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) memWait (
    .clk(clk),
    .reset(reset),
    .clr(state == EXEC),
    .en(state == MEM),
    .memReady(bus.memReady),
    .timeout(timeout)
  );
  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE:    nextState = bus.start ? FETCH : IDLE;
      FETCH:   nextState = bus.halt ? DONE : bus.instrValid ? DECODE : FETCH;
      DECODE:  nextState = EXEC;
      EXEC:    nextState = isJump ? FETCH : (isLoad || isStore) ? MEM : WB;
      MEM:     nextState = bus.memReady ? (isLoad ? WB : FETCH) : timeout ? DONE : MEM;
      WB:      nextState = FETCH;
      DONE:    nextState = bus.start ? FETCH : DONE;
      default: nextState = IDLE;
    endcase
  end
  assign bus.instrReady = state == FETCH;
  assign bus.aluSrc = (state == DECODE || state == EXEC || state == MEM) && usesImm(3'(irOp));
  assign bus.memRead = state == MEM && isLoad;
  assign bus.memWrite = state == MEM && isStore;
  assign bus.regWrite = state == WB;
  assign bus.branch = state == EXEC && isJump && JUMP_COND != 0;
  assign bus.jump = state == EXEC && isJump && (JUMP_COND == 0 || bus.zero);
  // A STORE retires in MEM itself, so its PC strobe is tied to the memReady cycle.
  assign bus.pcEn = state == WB || (state == EXEC && isJump) || (state == MEM && isStore && bus.memReady);
  assign bus.done = state == DONE;
  assign bus.memErr = memErr;
  assign bus.instrCount = instrCount;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      irOp <= '0;
      memErr <= 1'b0;
      instrCount <= '0;
    end else begin
      state <= nextState;
      if (state == FETCH && !bus.halt && bus.instrValid) irOp <= bus.opcode;
      if (timeout) memErr <= 1'b1;
      if (bus.pcEn && !(&instrCount)) instrCount <= instrCount + 1'b1;
    end
  end
endmodule
